prng_coeff_sampler: RTL
=======================

Name: prng_coeff_sampler

Overview:
- Downstream consumer of the 16-bit LFSR PRNG. Turns raw 16-bit PRNG words into N uniform polynomial coefficients in [0, Q) by masked rejection sampling.
- Accepted coefficients are written sequentially into a coefficient RAM, which feeds the polynomial/NTT datapath of the FHE accelerator.
- Drives the PRNG enable/start through a request line and consumes one word per PRNG valid pulse.

Parameters:
- Q, 12289: coefficient modulus. Must satisfy 2 <= Q <= 2^QBITS.
- QBITS, 14: candidate width; low QBITS bits of each PRNG word, with QBITS <= 16.
- N, 256: number of coefficients per polynomial. Must be a power of two, >= 2.
- AW, 8: address width, equal to log2(N).

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  single-cycle request to sample one polynomial; honoured only in IDLE
- prng_word  in  16  PRNG output word (connects to prng_gen)
- prng_valid  in  1  prng_word is fresh this cycle; consumed once (connects to PRNG done)
- prng_req  out  1  sampler wants words (drives PRNG en/start)
- coef_we  out  1  coefficient RAM write enable
- coef_addr  out  AW  coefficient RAM address
- coef_data  out  QBITS  coefficient value, always < Q
- busy  out  1  high from the cycle after accepted start through the DONE state
- done  out  1  one-cycle pulse after the final write
- reject_cnt  out  16  rejections in the current/last run, saturating at 0xFFFF

Behaviour:
- Interface decision: one clock, clk. Reset is rst, synchronous, active-high.
- Reset: state=IDLE. prng_req, coef_we, busy and done = 0. coef_addr, coef_data and reject_cnt = 0. Internal idx = 0.
- Reset has priority over every other input. Asserting it mid-run aborts the run immediately, with no further writes and no done pulse.
- States: IDLE, SAMPLE, DONE.
- IDLE:
  - start=1 moves to SAMPLE at the next edge, clearing idx and reject_cnt.
  - prng_valid is ignored.
- SAMPLE:
  - prng_req = 1, decoded combinationally from state.
  - busy = 1 (registered).
  - On an edge with prng_valid=1, cand = prng_word[QBITS-1:0].
  - If cand < Q, the edge registers coef_we=1, coef_addr=idx and coef_data=cand, then increments idx. Write latency is 1 cycle after the valid cycle.
  - If cand >= Q, coef_we=0 and reject_cnt increments (saturating).
  - prng_valid=0 causes no write and no count; prng_req stays high.
  - If the accepted candidate has idx == N-1, the same edge moves to DONE. idx wraps to 0.
- DONE (exactly one cycle):
  - Holds the final coef_we=1.
  - prng_req = 0; prng_valid is ignored.
  - Next edge: done=1, busy=0, coef_we=0, state=IDLE.
- coef_we is high only in the cycle after an accepted word. coef_addr and coef_data hold their last values when coef_we=0.
- start while busy (SAMPLE or DONE) is ignored. start during the done cycle is honoured, giving back-to-back runs.
- Addresses are written strictly 0..N-1 in order, each exactly once per run.
- reject_cnt is held after done until the next accepted start.
- No timeout: a stalled PRNG leaves the block in SAMPLE indefinitely.

Test Plan:
- Reset, using N=4, Q=12289, QBITS=14 for all scenarios: hold rst for 2 cycles -> all outputs 0, prng_req=0, state IDLE.
- Nominal run: start, then valid words 0x0005, 0x3000, 0x3001, 0xFFFF, 0xC00A, 0x0001 on consecutive cycles.
  - Expected writes: (0,5), (1,12288), (2,10), (3,1).
  - reject_cnt=2.
  - done pulses the cycle after the write to address 3.
  - prng_req is low from the final-write cycle onward.
- Valid gaps: the same word stream with prng_valid low for 3 cycles between words -> identical writes, no coef_we during gaps, prng_req held high.
- Start during busy: pulse start after the second write -> ignored. Exactly 4 writes, one done pulse, reject_cnt unaffected.
- Reset mid-run: assert rst after 2 accepted writes -> next cycle all outputs 0. A new start then writes from address 0 with reject_cnt restarting at 0.
- Idle noise: prng_valid=1 with word 0x0007 while in IDLE -> no coef_we, reject_cnt unchanged, prng_req=0.

Source files
------------

// File: rtl/prng_coeff_sampler.sv
// prng_coeff_sampler: rejection-samples PRNG words into N coefficients in [0,Q) and writes them to coefficient RAM.
module prng_coeff_sampler #(
  parameter int Q     = 12289,
  parameter int QBITS = 14,
  parameter int N     = 256,
  parameter int AW    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [15:0]      prng_word,
  input  logic             prng_valid,
  output logic             prng_req,
  output logic             coef_we,
  output logic [AW-1:0]    coef_addr,
  output logic [QBITS-1:0] coef_data,
  output logic             busy,
  output logic             done,
  output logic [15:0]      reject_cnt
);
  typedef enum logic [1:0] {IDLE, SAMPLE, DONE} state_t;
  localparam logic [QBITS:0] QV = (QBITS+1)'(Q);
  state_t state, state_nx;
  logic [AW-1:0] idx;
  logic [QBITS-1:0] cand;
  logic accept, reject, last;
  assign cand     = prng_word[QBITS-1:0];
  assign accept   = state == SAMPLE && prng_valid && {1'b0, cand} < QV;
  assign reject   = state == SAMPLE && prng_valid && !({1'b0, cand} < QV);
  assign last     = idx == AW'(N-1);
  assign prng_req = state == SAMPLE;
  always_comb begin
    state_nx = state;
    state_nx = state == IDLE   ? (start ? SAMPLE : IDLE) :
               state == SAMPLE ? (accept && last ? DONE : SAMPLE) : IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      idx        <= '0;
      coef_we    <= 1'b0;
      coef_addr  <= '0;
      coef_data  <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      reject_cnt <= '0;
    end else begin
      state   <= state_nx;
      busy    <= state_nx != IDLE;
      done    <= state == DONE;
      coef_we <= accept;
      if (state == IDLE && start) begin
        idx        <= '0;
        reject_cnt <= '0;
      end
      if (accept) begin
        coef_addr <= idx;
        coef_data <= cand;
        idx       <= idx + AW'(1);
      end
      if (reject && reject_cnt != 16'hFFFF) reject_cnt <= reject_cnt + 16'd1;
    end
  end
endmodule
